forward_pass: RTL and testbench

//  Sequential inference engine for the 2-8-3 MLP: Z0=W0*x+b0, A0=ReLU(Z0), Z1=W1*A0+b1, argmax(Z1).

---
 rtl/mlp_pkg.sv | 28 ++
 rtl/fwd_mac.sv | 49 ++++
 rtl/forward_pass.sv | 170 +++++++++++++++++
 tb/tb_forward_pass.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared sizes, FSM encoding and fixed-point helpers for the 2-8-3 MLP inference path.
package mlp_pkg;

  localparam int N_IN     = 2;
  localparam int N_HID    = 8;
  localparam int N_OUT    = 3;
  localparam int DW_DEF   = 16;
  localparam int FRAC_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    L0     = 2'd1,
    L1     = 2'd2,
    ARGMAX = 2'd3
  } state_t;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      sat = hi;
    else if (v < lo) sat = lo;
    else             sat = v;
  endfunction

endpackage

// File: rtl/fwd_mac.sv
// Shared multiply-accumulate: acc = (first ? bias<<FRAC : acc) + a*b, with a saturated
// Q-format view of the value being accumulated this cycle.
module fwd_mac
  import mlp_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int FRAC = FRAC_DEF,
  parameter int ACCW = 2 * DW + 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 first,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  input  logic signed [DW-1:0] bias,
  output logic signed [DW-1:0] result
);

  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] bias_ext;
  logic signed [ACCW-1:0] base;
  logic signed [ACCW-1:0] sum;
  logic signed [ACCW-1:0] shifted;
  logic signed [63:0]     wide;
  logic signed [ACCW-1:0] acc_q;

  always_comb begin
    prod     = a * b;
    prod_ext = {{(ACCW - 2 * DW){prod[2*DW-1]}}, prod};
    bias_ext = {{(ACCW - DW){bias[DW-1]}}, bias};
    base     = first ? (bias_ext <<< FRAC) : acc_q;
    sum      = base + prod_ext;
    // Arithmetic shift floors toward -inf before saturation.
    shifted  = sum >>> FRAC;
    wide     = {{(64 - ACCW){shifted[ACCW-1]}}, shifted};
    result   = DW'(sat(wide, DW));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= sum;
    end
  end

endmodule

// File: rtl/forward_pass.sv
// Sequential 2-8-3 MLP forward pass: hidden layer with ReLU, output logits and argmax,
// all computed one MAC per cycle through a single shared fwd_mac.
module forward_pass
  import mlp_pkg::*;
#(
  parameter int DATAWIDTH = DW_DEF,
  parameter int FRAC      = FRAC_DEF,
  parameter int ACCW      = 2 * DATAWIDTH + 4
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic [N_IN-1:0][DATAWIDTH-1:0]             inputs,
  input  logic [N_HID-1:0][N_IN-1:0][DATAWIDTH-1:0]  currW0,
  input  logic [N_HID-1:0][DATAWIDTH-1:0]            currb0,
  input  logic [N_OUT-1:0][N_HID-1:0][DATAWIDTH-1:0] currW1,
  input  logic [N_OUT-1:0][DATAWIDTH-1:0]            currb1,
  output logic                                       busy,
  output logic                                       done,
  output logic [N_HID-1:0][DATAWIDTH-1:0]            reluout,
  output logic [N_OUT-1:0][DATAWIDTH-1:0]            logits,
  output logic [1:0]                                 predictedstate,
  output state_t                                     state_dbg
);

  // Handshake: start is sampled only in IDLE; busy covers L0/L1; done is a one-cycle
  // pulse in ARGMAX, during which busy is already low and start is still ignored.

  state_t                       state_q, state_d;
  logic [2:0]                   n_q;
  logic [2:0]                   k_q;
  logic [1:0]                   j;
  logic [N_IN-1:0][DATAWIDTH-1:0] x_reg;
  logic [1:0]                   pred_q;
  logic [1:0]                   argmax_c;

  logic                         mac_en;
  logic                         mac_first;
  logic                         mac_last;
  logic signed [DATAWIDTH-1:0]  mac_a;
  logic signed [DATAWIDTH-1:0]  mac_b;
  logic signed [DATAWIDTH-1:0]  mac_bias;
  logic signed [DATAWIDTH-1:0]  mac_result;

  assign j = n_q[1:0];

  fwd_mac #(
    .DW   (DATAWIDTH),
    .FRAC (FRAC),
    .ACCW (ACCW)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (mac_en),
    .first  (mac_first),
    .a      (mac_a),
    .b      (mac_b),
    .bias   (mac_bias),
    .result (mac_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = L0;
      L0:      if (k_q == 3'd1 && n_q == 3'd7) state_d = L1;
      L1:      if (k_q == 3'd7 && n_q == 3'd2) state_d = ARGMAX;
      ARGMAX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand selection for the shared MAC.
  always_comb begin
    mac_en    = 1'b0;
    mac_first = 1'b0;
    mac_last  = 1'b0;
    mac_a     = '0;
    mac_b     = '0;
    mac_bias  = '0;
    case (state_q)
      L0: begin
        mac_en    = 1'b1;
        mac_first = (k_q == 3'd0);
        mac_last  = (k_q == 3'd1);
        mac_a     = currW0[n_q][k_q[0]];
        mac_b     = x_reg[k_q[0]];
        mac_bias  = currb0[n_q];
      end
      L1: begin
        mac_en    = 1'b1;
        mac_first = (k_q == 3'd0);
        mac_last  = (k_q == 3'd7);
        mac_a     = currW1[j][k_q];
        mac_b     = reluout[k_q];
        mac_bias  = currb1[j];
      end
      default: ;
    endcase
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    logic signed [DATAWIDTH-1:0] best;
    best     = logits[0];
    argmax_c = 2'd0;
    if ($signed(logits[1]) > best) begin
      best     = logits[1];
      argmax_c = 2'd1;
    end
    if ($signed(logits[2]) > best) begin
      argmax_c = 2'd2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q     <= '0;
      k_q     <= '0;
      x_reg   <= '0;
      reluout <= '0;
      logits  <= '0;
      pred_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            x_reg <= inputs;
            n_q   <= '0;
            k_q   <= '0;
          end
        end
        L0: begin
          if (mac_last) begin
            reluout[n_q] <= mac_result[DATAWIDTH-1] ? '0 : mac_result;
            k_q          <= '0;
            n_q          <= (n_q == 3'd7) ? 3'd0 : n_q + 3'd1;
          end else begin
            k_q <= k_q + 3'd1;
          end
        end
        L1: begin
          if (mac_last) begin
            logits[j] <= mac_result;
            k_q       <= '0;
            n_q       <= (n_q == 3'd2) ? 3'd0 : n_q + 3'd1;
          end else begin
            k_q <= k_q + 3'd1;
          end
        end
        ARGMAX: pred_q <= argmax_c;
        default: ;
      endcase
    end
  end

  assign busy           = (state_q == L0) || (state_q == L1);
  assign done           = (state_q == ARGMAX);
  assign predictedstate = done ? argmax_c : pred_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_forward_pass.sv
// Directed bench for forward_pass: hand-computed vectors for layers, saturation, argmax ties,
// start handling around busy/done and asynchronous reset mid-pass.
module tb_forward_pass;
  import mlp_pkg::*;

  localparam int DW = 16;

  logic                          clk;
  logic                          rst_n;
  logic                          start;
  logic [N_IN-1:0][DW-1:0]       inputs;
  logic [N_HID-1:0][N_IN-1:0][DW-1:0]  w0;
  logic [N_HID-1:0][DW-1:0]      b0;
  logic [N_OUT-1:0][N_HID-1:0][DW-1:0] w1;
  logic [N_OUT-1:0][DW-1:0]      b1;
  logic                          busy;
  logic                          done;
  logic [N_HID-1:0][DW-1:0]      reluout;
  logic [N_OUT-1:0][DW-1:0]      logits;
  logic [1:0]                    predictedstate;
  state_t                        state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  int         done_at;
  int         n_done;
  int         busy_err;
  logic [1:0] pred_at_done;

  forward_pass #(.DATAWIDTH(DW), .FRAC(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .inputs         (inputs),
    .currW0         (w0),
    .currb0         (b0),
    .currW1         (w1),
    .currb1         (b1),
    .busy           (busy),
    .done           (done),
    .reluout        (reluout),
    .logits         (logits),
    .predictedstate (predictedstate),
    .state_dbg      (state_dbg)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_params();
    inputs = '0;
    w0     = '0;
    b0     = '0;
    w1     = '0;
    b1     = '0;
  endtask

  task automatic exp_push(input int v);
    exp_q.push_back(v[DW-1:0]);
  endtask

  // Scoreboard: pops 8 reluout then 3 logits expectations.
  task automatic check_outputs(input string tag);
    logic [DW-1:0] e;
    for (int i = 0; i < N_HID; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check($sformatf("%s_relu%0d", tag, i), $signed(reluout[i]), $signed(e));
    end
    for (int i = 0; i < N_OUT; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check($sformatf("%s_logit%0d", tag, i), $signed(logits[i]), $signed(e));
    end
  endtask

  // One pass: start accepted at the posedge after the first negedge; cycle c is the
  // cycle following accept edge c-1. Optionally re-pulses start in cycle pulse_cyc.
  task automatic run_pass(input int pulse_cyc, output int d_at, output int n_d,
                          output int b_err, output logic [1:0] p_at);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    d_at  = 0;
    n_d   = 0;
    b_err = 0;
    p_at  = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = (c == pulse_cyc);
      if (done === 1'b1) begin
        n_d++;
        if (d_at == 0) begin
          d_at = c;
          p_at = predictedstate;
        end
      end
      if (busy !== (c <= 40)) b_err++;
    end
    start = 1'b0;
  endtask

  task automatic check_pass(input string tag, input int exp_pred);
    check({tag, "_done_at"}, done_at, 41);
    check({tag, "_n_done"}, n_done, 1);
    check({tag, "_busy"}, busy_err, 0);
    check({tag, "_pred_done"}, pred_at_done, exp_pred);
    check({tag, "_pred_hold"}, predictedstate, exp_pred);
    check_outputs(tag);
  endtask

  task automatic load_test2();
    clear_params();
    inputs[0] = -16'sd512;
    w0[0][0]  = 16'd256;
    w0[1][0]  = 16'd256;
    w0[1][1]  = 16'd256;
    b0[1]     = 16'd1024;
    w0[3][0]  = -16'sd1;
    w0[5][0]  = -16'sd1;
    w1[0][1]  = 16'd128;
    w1[1][3]  = 16'd300;
    b1[1]     = 16'd10;
    w1[2][5]  = -16'sd100;
  endtask

  task automatic load_test4b();
    clear_params();
    b1[0] = -16'sd5;
    b1[1] = 16'd7;
    b1[2] = 16'd7;
  endtask

  initial begin
    int d2;
    rst_n = 1'b0;
    start = 1'b0;
    clear_params();

    // Reset state.
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pred", predictedstate, 0);
    check("rst_relu", |reluout, 0);
    check("rst_logits", |logits, 0);
    check("rst_state", state_dbg, IDLE);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: biases pass straight through to logits.
    clear_params();
    b1[0] = 16'd256;
    b1[1] = 16'd512;
    b1[2] = 16'd128;
    for (int i = 0; i < N_HID; i++) exp_push(0);
    exp_push(256); exp_push(512); exp_push(128);
    run_pass(0, done_at, n_done, busy_err, pred_at_done);
    check_pass("t1", 1);

    // 2: ReLU clipping, positive neuron, fractional weights with floor in layer 1.
    load_test2();
    exp_push(0); exp_push(512); exp_push(0); exp_push(2);
    exp_push(0); exp_push(2);   exp_push(0); exp_push(0);
    exp_push(256); exp_push(12); exp_push(-1);
    run_pass(0, done_at, n_done, busy_err, pred_at_done);
    check_pass("t2", 0);

    // 3: saturation at both rails; equal logits resolve to index 0.
    clear_params();
    inputs = {N_IN{16'h7FFF}};
    w0     = {(N_HID*N_IN){16'h7FFF}};
    b0     = {N_HID{16'h7FFF}};
    w1     = {(N_OUT*N_HID){16'h8001}};
    for (int i = 0; i < N_HID; i++) exp_push(32767);
    for (int i = 0; i < N_OUT; i++) exp_push(-32768);
    run_pass(0, done_at, n_done, busy_err, pred_at_done);
    check_pass("t3", 0);

    // 4a: three-way tie -> lowest index.
    clear_params();
    b1 = {N_OUT{16'd300}};
    for (int i = 0; i < N_HID; i++) exp_push(0);
    exp_push(300); exp_push(300); exp_push(300);
    run_pass(0, done_at, n_done, busy_err, pred_at_done);
    check_pass("t4a", 0);

    // 4b: tie between 1 and 2 -> 1.
    load_test4b();
    for (int i = 0; i < N_HID; i++) exp_push(0);
    exp_push(-5); exp_push(7); exp_push(7);
    run_pass(0, done_at, n_done, busy_err, pred_at_done);
    check_pass("t4b", 1);

    // 5a: start pulse while busy is ignored.
    load_test2();
    exp_push(0); exp_push(512); exp_push(0); exp_push(2);
    exp_push(0); exp_push(2);   exp_push(0); exp_push(0);
    exp_push(256); exp_push(12); exp_push(-1);
    run_pass(10, done_at, n_done, busy_err, pred_at_done);
    check_pass("t5a", 0);

    // 5b: start raised in the done cycle is taken on the following IDLE cycle.
    load_test4b();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    done_at = 0;
    for (int c = 1; c <= 60 && done_at == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        done_at = c;
        start   = 1'b1;
      end
    end
    check("t5b_first_done_at", done_at, 41);
    @(negedge clk);
    check("t5b_not_taken_busy", busy, 0);
    check("t5b_not_taken_state", state_dbg, IDLE);
    @(posedge clk);
    d2 = 0;
    for (int c = 1; c <= 60 && d2 == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) d2 = c + 1;
    end
    start = 1'b0;
    check("t5b_done_after_done_cycle", d2, 42);
    check("t5b_pred", predictedstate, 1);

    // 6: asynchronous reset mid-pass, then a clean pass.
    load_test2();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("t6_mid_relu1", $signed(reluout[1]), 512);
    check("t6_mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_relu", |reluout, 0);
    check("t6_rst_logits", |logits, 0);
    check("t6_rst_pred", predictedstate, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done   = 0;
    busy_err = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
      if (busy !== 1'b0) busy_err++;
    end
    check("t6_no_done", n_done, 0);
    check("t6_idle_busy", busy_err, 0);
    load_test4b();
    for (int i = 0; i < N_HID; i++) exp_push(0);
    exp_push(-5); exp_push(7); exp_push(7);
    run_pass(0, done_at, n_done, busy_err, pred_at_done);
    check_pass("t6_after", 1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
